// File: rtl/psys_route_arbiter_if.sv
// Beat-stream bundle between NUM_SRC requesters, the route arbiter and the downstream packer.
// No storage and no latency; it only groups the wires.
// The arbiter uses the master view, and the requesters and packer use the slave view.
interface psys_route_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 1536,
  parameter int SRC_W   = 2
) ();
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [SRC_W-1:0]          m_axis_tid;
  logic                      m_axis_tlast;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid, m_axis_tlast
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid, m_axis_tlast
  );
endinterface

// File: rtl/psys_route_arbiter.sv
// Round-robin arbiter that locks one source for a whole packed word and tags each beat with its source index and word-last flag.
// The grant is registered one cycle after a request, and after that the data passes through combinationally with zero latency.
// s_axis_tready of the granted source follows m_axis_tready, so a dropped valid or low ready stalls the burst with no timeout.
module psys_route_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int DATA_W         = 1536,
  parameter int BEATS_PER_WORD = 4,
  parameter int SRC_W          = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  src_en,
  psys_route_arbiter_if.master bus,
  output logic                busy,
  output logic [15:0]         word_cnt
);

  localparam int BC_W = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_n;
  logic [SRC_W-1:0]  grant, grant_n;
  logic [BC_W-1:0]   beat_cnt, beat_cnt_n;
  logic [SRC_W-1:0]  rr_ptr, rr_ptr_n;
  logic [15:0]       word_cnt_n;

  logic [NUM_SRC-1:0] req;
  logic               hs;
  logic               last_beat;
  logic               word_done;
  logic [SRC_W-1:0]   next_ptr;
  logic [SRC_W-1:0]   arb_ptr;
  logic               win_vld;
  logic [SRC_W-1:0]   win_idx;

  assign req       = bus.s_axis_tvalid & src_en;
  assign last_beat = (beat_cnt == BC_W'(BEATS_PER_WORD - 1));
  assign hs        = (state == BURST) && bus.s_axis_tvalid[grant] && bus.m_axis_tready;
  assign word_done = hs && last_beat;
  assign next_ptr  = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
  // On word completion, search from the updated pointer so that the finishing source gets the lowest priority.
  assign arb_ptr   = word_done ? next_ptr : rr_ptr;

  // The first requester found at or above arb_ptr (wrapping modulo NUM_SRC) wins. The loop runs downward so that the nearest one is written last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[(int'(arb_ptr) + k) % NUM_SRC]) begin
        win_vld = 1'b1;
        win_idx = SRC_W'((int'(arb_ptr) + k) % NUM_SRC);
      end
    end
  end

  // State and counter registers. Reset clears them and drops any word that is partly sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      beat_cnt <= beat_cnt_n;
      rr_ptr   <= rr_ptr_n;
      word_cnt <= word_cnt_n;
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats in BURST, and re-arbitrate on the last beat so that words follow each other without a bubble.
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    beat_cnt_n = beat_cnt;
    rr_ptr_n   = rr_ptr;
    word_cnt_n = word_cnt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_n    = win_idx;
          beat_cnt_n = '0;
          state_n    = BURST;
        end
      end
      BURST: begin
        if (hs) begin
          if (!last_beat) begin
            beat_cnt_n = beat_cnt + BC_W'(1);
          end else begin
            word_cnt_n = word_cnt + 16'd1;
            rr_ptr_n   = next_ptr;
            if (win_vld) begin
              grant_n    = win_idx;
              beat_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic: all outputs are quiet in IDLE. In BURST the granted source's beat passes straight through.
  always_comb begin
    bus.s_axis_tready = '0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tid    = '0;
    bus.m_axis_tlast  = 1'b0;
    busy              = 1'b0;
    if (state == BURST) begin
      bus.m_axis_tdata         = bus.s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
      bus.m_axis_tvalid        = bus.s_axis_tvalid[grant];
      bus.m_axis_tid           = grant;
      bus.m_axis_tlast         = last_beat;
      bus.s_axis_tready[grant] = bus.m_axis_tready;
      busy                     = 1'b1;
    end
  end

endmodule

// File: tb/tb_psys_route_arbiter.sv
// Self-checking bench for psys_route_arbiter: directed scenarios plus a random phase, compared against a word-level reference model.
// A second small instance with one-beat words exercises the 16-bit word counter wrap.
module tb_psys_route_arbiter;
  localparam int N  = 4;
  localparam int DW = 1536;
  localparam int B  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [N-1:0] src_en;
  logic        busy;
  logic [15:0] word_cnt;

  logic        w_rst;
  logic [1:0]  w_en;
  logic        w_busy;
  logic [15:0] w_wc;

  always #5 clk = ~clk;

  psys_route_arbiter_if #(.NUM_SRC(N), .DATA_W(DW), .SRC_W(2)) bus ();
  psys_route_arbiter_if #(.NUM_SRC(2), .DATA_W(8), .SRC_W(1)) wbus ();

  psys_route_arbiter #(.NUM_SRC(N), .DATA_W(DW), .BEATS_PER_WORD(B), .SRC_W(2)) dut (
    .clk(clk), .rst(rst), .src_en(src_en), .bus(bus.master), .busy(busy), .word_cnt(word_cnt)
  );

  psys_route_arbiter #(.NUM_SRC(2), .DATA_W(8), .BEATS_PER_WORD(1), .SRC_W(1)) u_wrap (
    .clk(clk), .rst(w_rst), .src_en(w_en), .bus(wbus.master), .busy(w_busy), .word_cnt(w_wc)
  );

  // Reference model state: owner of the current word, beats already taken, priority pointer, word tally
  int m_busy, m_g, m_beats, m_ptr, m_words;
  int n_cmp = 0;
  int n_err = 0;
  int acc_tid[$];
  int n_last;

  function automatic int arb(input int ptr, input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check the combinational outputs at mid-cycle, then advance the model on the edge
  task automatic cycle();
    logic [N-1:0]  e_trdy;
    logic          e_tv, e_tl, hs;
    int            e_tid, w;
    logic [DW-1:0] e_dat;
    logic [N-1:0]  req;
    #2;
    e_trdy = '0; e_tv = 1'b0; e_tl = 1'b0; e_tid = 0; e_dat = '0;
    if (m_busy != 0) begin
      e_tv = bus.s_axis_tvalid[m_g];
      e_tid = m_g;
      e_tl = (m_beats == B - 1);
      e_trdy[m_g] = bus.m_axis_tready;
      e_dat = bus.s_axis_tdata[m_g*DW +: DW];
    end
    chk("busy", 64'(busy), 64'(m_busy != 0));
    chk("s_tready", 64'(bus.s_axis_tready), 64'(e_trdy));
    chk("m_tvalid", 64'(bus.m_axis_tvalid), 64'(e_tv));
    chk("m_tid", 64'(bus.m_axis_tid), 64'(e_tid));
    chk("m_tlast", 64'(bus.m_axis_tlast), 64'(e_tl));
    chk("word_cnt", 64'(word_cnt), 64'(m_words));
    n_cmp++;
    assert (bus.m_axis_tdata === e_dat) else begin
      n_err++;
      $error("FAIL tdata: observed[63:0] %0h expected[63:0] %0h", bus.m_axis_tdata[63:0], e_dat[63:0]);
    end
    hs = (m_busy != 0) && e_tv && bus.m_axis_tready;
    req = bus.s_axis_tvalid & src_en;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_g = 0; m_beats = 0; m_ptr = 0; m_words = 0;
    end else if (m_busy == 0) begin
      w = arb(m_ptr, req);
      if (w >= 0) begin m_busy = 1; m_g = w; m_beats = 0; end
    end else if (hs) begin
      acc_tid.push_back(m_g);
      if (m_beats < B - 1) m_beats++;
      else begin
        n_last++;
        m_words = (m_words + 1) % 65536;
        m_ptr = (m_g + 1) % N;
        w = arb(m_ptr, req);
        if (w >= 0) begin m_g = w; m_beats = 0; end
        else m_busy = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      for (int s = 0; s < N; s++)
        for (int c = 0; c < DW/32; c++)
          bus.s_axis_tdata[s*DW + c*32 +: 32] = $urandom;
      cycle();
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    acc_tid.delete();
    n_last = 0;
  endtask

  initial begin
    int pat[7] = '{1, 0, 0, 1, 1, 0, 0};
    int cnt;
    m_busy = 0; m_g = 0; m_beats = 0; m_ptr = 0; m_words = 0; n_last = 0;
    rst = 1'b1; src_en = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = '0; bus.m_axis_tready = 1'b0;
    w_rst = 1'b1; w_en = 2'b11;
    wbus.s_axis_tdata = 16'hA55A; wbus.s_axis_tvalid = 2'b11; wbus.m_axis_tready = 1'b1;
    @(negedge clk);
    run(2);
    chk("reset_word_cnt", 64'(word_cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    acc_tid.delete(); n_last = 0;

    // Single source, 8 beats; the mask drops on the final beat so that no new word starts
    src_en = 4'b0001; bus.s_axis_tvalid = 4'b0001; bus.m_axis_tready = 1'b1;
    run(8);
    src_en = 4'b0000;
    run(1);
    bus.s_axis_tvalid = '0;
    run(2);
    chk("t1_words", 64'(word_cnt), 64'd2);
    chk("t1_beats", 64'(acc_tid.size()), 64'd8);
    chk("t1_tlast", 64'(n_last), 64'd2);
    foreach (acc_tid[i]) chk("t1_tid", 64'(acc_tid[i]), 64'd0);

    // All sources request: words go 0,1,2,3,0,1 back to back
    do_rst();
    src_en = 4'b1111; bus.s_axis_tvalid = 4'b1111;
    run(1);
    run(23);
    src_en = 4'b0000;
    run(1);
    bus.s_axis_tvalid = '0;
    run(1);
    chk("t2_beats", 64'(acc_tid.size()), 64'd24);
    foreach (acc_tid[i]) chk("t2_order", 64'(acc_tid[i]), 64'((i / 4) % 4));

    // Backpressure during a src2 burst
    do_rst();
    src_en = 4'b0100; bus.s_axis_tvalid = 4'b0100; bus.m_axis_tready = 1'b1;
    run(1);
    foreach (pat[i]) begin
      bus.m_axis_tready = pat[i][0];
      run(1);
    end
    bus.m_axis_tready = 1'b1; src_en = 4'b0000;
    run(1);
    bus.s_axis_tvalid = '0;
    run(1);
    chk("t3_beats", 64'(acc_tid.size()), 64'd4);
    chk("t3_words", 64'(word_cnt), 64'd1);
    foreach (acc_tid[i]) chk("t3_tid", 64'(acc_tid[i]), 64'd2);

    // src1 stalls after 2 beats while its enable is cleared; the grant holds
    do_rst();
    src_en = 4'b0010; bus.s_axis_tvalid = 4'b0010;
    run(3);
    bus.s_axis_tvalid = '0; src_en = 4'b0000;
    run(3);
    chk("t4_stall_busy", 64'(busy), 64'd1);
    chk("t4_stall_tid", 64'(bus.m_axis_tid), 64'd1);
    bus.s_axis_tvalid = 4'b0010;
    run(5);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_words", 64'(word_cnt), 64'd1);
    chk("t4_beats", 64'(acc_tid.size()), 64'd4);

    // Reset mid-burst of src3; afterwards src0 beats src3
    do_rst();
    src_en = 4'b1000; bus.s_axis_tvalid = 4'b1000;
    run(2);
    src_en = 4'b1001; bus.s_axis_tvalid = 4'b1001; rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("t5_wc", 64'(word_cnt), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_trdy", 64'(bus.s_axis_tready), 64'd0);
    run(1);
    chk("t5_tid", 64'(bus.m_axis_tid), 64'd0);
    chk("t5_busy_after", 64'(busy), 64'd1);
    run(3);
    src_en = 4'b0000;
    run(1);
    bus.s_axis_tvalid = '0;
    run(1);

    // Random phase
    repeat (400) begin
      rst = ($urandom_range(63) == 0);
      src_en = 4'($urandom);
      bus.s_axis_tvalid = 4'($urandom);
      bus.m_axis_tready = 1'($urandom);
      run(1);
    end
    rst = 1'b0; src_en = '0; bus.s_axis_tvalid = '0;
    run(2);

    // Word counter wrap with one-beat words
    w_rst = 1'b0;
    cnt = 0;
    while (w_wc !== 16'hFFFF && cnt < 70000) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    chk("wrap_cycles", 64'(cnt), 64'd65536);
    chk("wrap_ffff", 64'(w_wc), 64'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_zero", 64'(w_wc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
